// File: rtl/pc_fetch_unit_pkg.sv
// Shared definitions for the fetch PC unit: reset address, redirect kinds, FSM states.
// Imported by the target selector and the top-level register/FSM block.
package pc_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        KIND_BR   = 2'd0,
        KIND_J    = 2'd1,
        KIND_JR   = 2'd2,
        KIND_RSVD = 2'd3
    } redir_kind_e;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_npc.sv
// npc_sel: combinational redirect-target selection and alignment check; zero latency.
// A live redirect wins over the pending address; no flow control of its own.
module npc_sel
    import pc_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic [31:0] br_target,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_addr,
    input  logic [31:0] pend_addr,
    output logic        redir_hit,
    output logic [31:0] sel_raw,
    output logic [31:0] npc,
    output logic        npc_misalign
);

    logic [31:0] live_tgt;

    always_comb begin
        live_tgt  = br_target;
        redir_hit = 1'b0;
        case (redir_kind_e'(redir_kind))
            KIND_BR: begin
                live_tgt  = br_target;
                redir_hit = redir_valid;
            end
            KIND_J: begin
                // Region bits come from the delay-slot pc currently in fetch.
                live_tgt  = {pc[31:28], j_index, 2'b00};
                redir_hit = redir_valid;
            end
            KIND_JR: begin
                live_tgt  = jr_addr;
                redir_hit = redir_valid;
            end
            default: begin
                live_tgt  = br_target;
                redir_hit = 1'b0;
            end
        endcase

        sel_raw      = redir_hit ? live_tgt : pend_addr;
        npc          = {sel_raw[31:2], 2'b00};
        npc_misalign = |sel_raw[1:0];
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register with stall-tolerant redirect capture; target visible one edge after an unstalled cycle.
// Under stall the pc holds and the newest redirect is parked in pend_addr until the stall clears.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redir_valid,
    input  logic [1:0]  redir_kind,
    input  logic [31:0] br_target,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_plus8,
    output logic        adel_f,
    output logic        redir_pending
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  pend_addr_q, pend_addr_d;
    logic         adel_q, adel_d;

    logic         redir_hit;
    logic [31:0]  sel_raw;
    logic [31:0]  npc;
    logic         npc_misalign;

    npc_sel u_npc_sel (
        .pc           (pc_q),
        .redir_valid  (redir_valid),
        .redir_kind   (redir_kind),
        .br_target    (br_target),
        .j_index      (j_index),
        .jr_addr      (jr_addr),
        .pend_addr    (pend_addr_q),
        .redir_hit    (redir_hit),
        .sel_raw      (sel_raw),
        .npc          (npc),
        .npc_misalign (npc_misalign)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_addr_d = pend_addr_q;
        adel_d      = adel_q;
        case (state_q)
            ST_RUN: begin
                if (!stall) begin
                    if (redir_hit) begin
                        pc_d   = npc;
                        adel_d = npc_misalign;
                    end else begin
                        pc_d   = pc_q + 32'd4;
                        adel_d = 1'b0;
                    end
                end else if (redir_hit) begin
                    pend_addr_d = sel_raw;
                    state_d     = ST_HOLD;
                end
            end
            default: begin
                if (stall) begin
                    if (redir_hit) begin
                        pend_addr_d = sel_raw;
                    end
                end else begin
                    // sel_raw already prefers a same-cycle redirect over pend_addr.
                    pc_d    = npc;
                    adel_d  = npc_misalign;
                    state_d = ST_RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            pc_q        <= RESET_PC;
            pend_addr_q <= 32'd0;
            adel_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_addr_q <= pend_addr_d;
            adel_q      <= adel_d;
        end
    end

    assign pc            = pc_q;
    assign pc_plus4      = pc_q + 32'd4;
    assign pc_plus8      = pc_q + 32'd8;
    assign adel_f        = adel_q;
    assign redir_pending = (state_q == ST_HOLD);

endmodule
